// File: rtl/rom_access_arbiter_pkg.sv
// Shared definitions for the ROM access arbiter.
// Holds the default port widths, the word-alignment mask and the encoding that
// records which requester owns an in-flight ROM access.
package rom_access_arbiter_pkg;

  localparam int unsigned ADDR_W_DEF = 12;
  localparam int unsigned DATA_W_DEF = 32;

  // Low address bits that must be zero for a word-aligned access.
  localparam logic [1:0] ALIGN_MASK = 2'b11;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LD = 1'b1
  } owner_e;

endpackage

// File: rtl/rom_arb_prio.sv
// Grant logic for the shared ROM port.
// LD wins by default. An IF requester that has watched LD_STREAK consecutive
// LD grants is forced through on the next cycle.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   if_req, ld_req  held requests from fetch and load paths
//   if_gnt, ld_gnt  combinational one-hot (or zero) grants, zero during reset
module rom_arb_prio #(
  parameter int unsigned LD_STREAK = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic if_req,
  input  logic ld_req,
  output logic if_gnt,
  output logic ld_gnt
);

  localparam logic [2:0] StreakMax = 3'(LD_STREAK);

  logic [2:0] streak_q, streak_d;
  logic       if_forced;

  // IF has been starved long enough and must take this slot.
  assign if_forced = if_req && (streak_q == StreakMax);

  always_comb begin
    if_gnt = 1'b0;
    ld_gnt = 1'b0;
    if (!rst) begin
      if (ld_req && !if_forced) begin
        ld_gnt = 1'b1;
      end else if (if_req) begin
        if_gnt = 1'b1;
      end
    end
  end

  // Counts LD grants taken while IF was waiting; saturates at the limit.
  always_comb begin
    streak_d = streak_q;
    if (!if_req || if_gnt) begin
      streak_d = '0;
    end else if (ld_gnt && (streak_q != StreakMax)) begin
      streak_d = streak_q + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end

endmodule

// File: rtl/rom_access_arbiter.sv
// Shares one combinational ROM port between instruction fetch (IF) and data
// loads (LD). Stage A registers the granted word address, stage B captures the
// ROM word into the owner's response register; rvalid follows the grant by
// exactly two cycles, one access per cycle.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   if_req/if_addr/if_flush           fetch request, address, flush in-flight
//   if_gnt/if_rvalid/if_rdata         fetch grant and response
//   ld_req/ld_addr                    load request and byte address
//   ld_gnt/ld_rvalid/ld_rdata/ld_err  load grant and response
//   rom_addr/rom_data                 registered ROM address, ROM word
module rom_access_arbiter
  import rom_access_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned LD_STREAK = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic              ld_gnt,
  output logic              ld_rvalid,
  output logic [DATA_W-1:0] ld_rdata,
  output logic              ld_err,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data
);

  localparam logic [ADDR_W-1:0] LowMask  = ADDR_W'(ALIGN_MASK);
  localparam logic [ADDR_W-1:0] AddrMask = ~LowMask;

  owner_e owner_q;
  logic   va_q;
  logic   err_q;
  logic   ld_misaligned;
  logic   if_capture;
  logic   ld_capture;

  assign ld_misaligned = |(ld_addr & LowMask);

  // A flush kills the fetch sitting in stage A; a grant in the same cycle is
  // the new target and is registered normally.
  assign if_capture = va_q && (owner_q == OWN_IF) && !if_flush;
  assign ld_capture = va_q && (owner_q == OWN_LD);

  rom_arb_prio #(
    .LD_STREAK (LD_STREAK)
  ) u_prio (
    .clk    (clk),
    .rst    (rst),
    .if_req (if_req),
    .ld_req (ld_req),
    .if_gnt (if_gnt),
    .ld_gnt (ld_gnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rom_addr  <= '0;
      va_q      <= 1'b0;
      owner_q   <= OWN_IF;
      err_q     <= 1'b0;
      if_rvalid <= 1'b0;
      ld_rvalid <= 1'b0;
      if_rdata  <= '0;
      ld_rdata  <= '0;
      ld_err    <= 1'b0;
    end else begin
      // Stage A
      va_q <= if_gnt | ld_gnt;
      if (ld_gnt) begin
        rom_addr <= ld_addr & AddrMask;
        owner_q  <= OWN_LD;
        err_q    <= ld_misaligned;
      end else if (if_gnt) begin
        rom_addr <= if_addr & AddrMask;
        owner_q  <= OWN_IF;
        err_q    <= 1'b0;
      end
      // Stage B
      if_rvalid <= if_capture;
      ld_rvalid <= ld_capture;
      if (if_capture) begin
        if_rdata <= rom_data;
      end
      if (ld_capture) begin
        ld_rdata <= err_q ? '0 : rom_data;
        ld_err   <= err_q;
      end
    end
  end

endmodule

// File: tb/tb_rom_access_arbiter.sv
// Self-checking bench for rom_access_arbiter: directed scenarios followed by
// randomized traffic, all compared against a transaction-level model.
module tb_rom_access_arbiter;

  localparam int LD_STREAK = 3;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [11:0] if_addr;
  logic        if_flush;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        ld_req;
  logic [11:0] ld_addr;
  logic        ld_gnt;
  logic        ld_rvalid;
  logic [31:0] ld_rdata;
  logic        ld_err;
  logic [11:0] rom_addr;
  logic [31:0] rom_data;

  rom_access_arbiter #(
    .ADDR_W    (12),
    .DATA_W    (32),
    .LD_STREAK (LD_STREAK)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_flush  (if_flush),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .ld_req    (ld_req),
    .ld_addr   (ld_addr),
    .ld_gnt    (ld_gnt),
    .ld_rvalid (ld_rvalid),
    .ld_rdata  (ld_rdata),
    .ld_err    (ld_err),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [11:0] a);
    case (a)
      12'h000: rom_word = 32'h23646566;
      12'h004: rom_word = 32'h696e6520;
      default: rom_word = {4'hC, a, 4'h3, ~a};
    endcase
  endfunction

  assign rom_data = rom_word(rom_addr);

  // Reference model: a list of promised responses with the cycle they are due.
  typedef struct {
    bit          own_ld;
    logic [31:0] data;
    bit          err;
    int          due;
  } resp_t;

  resp_t       pend[$];
  int          cyc = 0;
  int          streak_m = 0;
  logic [31:0] exp_if_rdata = '0;
  logic [31:0] exp_ld_rdata = '0;
  bit          exp_ld_err = 1'b0;
  logic [11:0] exp_rom_addr = '0;
  bit          armed = 1'b0;
  bit          seen_ld_gnt;
  int          checks = 0;
  int          passed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s cycle %0d: got %h expected %h", tag, cyc, obs, exp);
  endtask

  // One clock cycle: drive inputs, check outputs at negedge, advance the model.
  task automatic step(input bit r, input bit ir, input logic [11:0] ia, input bit fl,
                      input bit lr, input logic [11:0] la, output bit ig, output bit lg);
    bit e_if_rv;
    bit e_ld_rv;
    bit mis;
    rst      = r;
    if_req   = ir;
    if_addr  = ia;
    if_flush = fl;
    ld_req   = lr;
    ld_addr  = la;
    lg = !r && lr && !(ir && streak_m == LD_STREAK);
    ig = !r && ir && !lg;
    e_if_rv = 1'b0;
    e_ld_rv = 1'b0;
    for (int i = pend.size() - 1; i >= 0; i--) begin
      if (pend[i].due == cyc) begin
        if (pend[i].own_ld) begin
          e_ld_rv      = 1'b1;
          exp_ld_rdata = pend[i].data;
          exp_ld_err   = pend[i].err;
        end else begin
          e_if_rv      = 1'b1;
          exp_if_rdata = pend[i].data;
        end
        pend.delete(i);
      end
    end
    @(negedge clk);
    seen_ld_gnt = ld_gnt;
    check("if_gnt", 32'(if_gnt), 32'(ig));
    check("ld_gnt", 32'(ld_gnt), 32'(lg));
    if (armed) begin
      check("if_rvalid", 32'(if_rvalid), 32'(e_if_rv));
      check("ld_rvalid", 32'(ld_rvalid), 32'(e_ld_rv));
      check("if_rdata", if_rdata, exp_if_rdata);
      check("ld_rdata", ld_rdata, exp_ld_rdata);
      check("ld_err", 32'(ld_err), 32'(exp_ld_err));
      check("rom_addr", 32'(rom_addr), 32'(exp_rom_addr));
    end
    @(posedge clk);
    if (r) begin
      pend.delete();
      streak_m     = 0;
      exp_if_rdata = '0;
      exp_ld_rdata = '0;
      exp_ld_err   = 1'b0;
      exp_rom_addr = '0;
    end else begin
      if (fl) begin
        for (int i = pend.size() - 1; i >= 0; i--) begin
          if (!pend[i].own_ld && pend[i].due == cyc + 1) pend.delete(i);
        end
      end
      if (lg) begin
        mis = (la[1:0] != 2'b00);
        pend.push_back('{own_ld: 1'b1, data: mis ? 32'h0 : rom_word(la & 12'hFFC),
                         err: mis, due: cyc + 2});
        exp_rom_addr = la & 12'hFFC;
      end else if (ig) begin
        pend.push_back('{own_ld: 1'b0, data: rom_word(ia & 12'hFFC), err: 1'b0, due: cyc + 2});
        exp_rom_addr = ia & 12'hFFC;
      end
      if (!ir || ig) streak_m = 0;
      else if (lg && streak_m < LD_STREAK) streak_m++;
    end
    armed = 1'b1;
    cyc++;
    #1;
  endtask

  initial begin
    bit          gi, gl;
    bit          ir, lr, fl, r;
    logic [11:0] ia, la;
    logic [7:0]  order;

    // Reset
    step(1, 0, 12'h000, 0, 0, 12'h000, gi, gl);
    step(1, 0, 12'h000, 0, 0, 12'h000, gi, gl);

    // IF only, then back-to-back fetches
    step(0, 1, 12'h000, 0, 0, 12'h000, gi, gl);
    for (int i = 0; i < 3; i++) step(0, 0, 12'h000, 0, 0, 12'h000, gi, gl);
    step(0, 1, 12'h000, 0, 0, 12'h000, gi, gl);
    step(0, 1, 12'h004, 0, 0, 12'h000, gi, gl);
    for (int i = 0; i < 3; i++) step(0, 0, 12'h000, 0, 0, 12'h000, gi, gl);

    // Contention: both held, expected order LD LD LD IF LD LD LD IF
    order = '0;
    ia = 12'h010;
    la = 12'h100;
    for (int i = 0; i < 8; i++) begin
      step(0, 1, ia, 0, 1, la, gi, gl);
      order[7-i] = seen_ld_gnt;
      if (gi) ia = ia + 12'h004;
      if (gl) la = la + 12'h004;
    end
    check("grant_order", 32'(order), 32'h000000EE);
    for (int i = 0; i < 3; i++) step(0, 0, 12'h000, 0, 0, 12'h000, gi, gl);

    // Misaligned then aligned load
    step(0, 0, 12'h000, 0, 1, 12'h006, gi, gl);
    step(0, 0, 12'h000, 0, 0, 12'h000, gi, gl);
    step(0, 0, 12'h000, 0, 1, 12'h004, gi, gl);
    for (int i = 0; i < 3; i++) step(0, 0, 12'h000, 0, 0, 12'h000, gi, gl);

    // Flush with a simultaneous new fetch target
    step(0, 1, 12'h000, 0, 0, 12'h000, gi, gl);
    step(0, 1, 12'h004, 1, 0, 12'h000, gi, gl);
    for (int i = 0; i < 3; i++) step(0, 0, 12'h000, 0, 0, 12'h000, gi, gl);

    // Reset in the middle of traffic
    step(0, 0, 12'h000, 0, 1, 12'h008, gi, gl);
    step(1, 1, 12'h00C, 0, 0, 12'h000, gi, gl);
    for (int i = 0; i < 3; i++) step(0, 0, 12'h000, 0, 0, 12'h000, gi, gl);

    // Random traffic; requests stay up with a stable address until granted
    ir = 1'b0;
    lr = 1'b0;
    ia = '0;
    la = '0;
    for (int n = 0; n < 2000; n++) begin
      if (!ir && $urandom_range(0, 2) != 0) begin
        ir = 1'b1;
        ia = 12'($urandom) & 12'hFFC;
      end
      if (!lr && $urandom_range(0, 2) != 0) begin
        lr = 1'b1;
        la = 12'($urandom);
      end
      fl = ($urandom_range(0, 7) == 0);
      r  = ($urandom_range(0, 99) == 0);
      step(r, ir, ia, fl, lr, la, gi, gl);
      if (gi) ir = 1'b0;
      if (gl) lr = 1'b0;
    end
    for (int i = 0; i < 3; i++) step(0, 0, 12'h000, 0, 0, 12'h000, gi, gl);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
